// File: rtl/tcm4671_pkg.sv
// Shared constants and FSM state type for the TMC4671-style SPI target.
`timescale 1ns/1ps
package tcm4671_pkg;

    localparam int FRAME_BITS = 40;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 32;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        DATA    = 2'd2,
        WAIT_CS = 2'd3
    } state_e;

endpackage

// File: rtl/tcm4671_sync.sv
// Two-flop synchronizer for an asynchronous level, plus single-cycle
// rise/fall pulses derived from the synchronized level.
`timescale 1ns/1ps
module tcm4671_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Metastability chain followed by a history flop for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/tcm4671_spi_target.sv
// SPI target with a 40-bit frame (R/W bit, 7-bit address, 32-bit data)
// backed by a small register file, all logic in the clk domain.
`timescale 1ns/1ps
module tcm4671_spi_target
    import tcm4671_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              SCK,
    input  logic              nSCS,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_oe,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_strobe,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              frame_error,
    input  logic [ADDR_W-1:0] host_addr,
    output logic [DATA_W-1:0] host_data
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W:0] NUM_REGS_L = 8'(NUM_REGS);
    localparam logic [CNT_W-1:0] CNT_ADDR_LAST = 6'd7;
    localparam logic [CNT_W-1:0] CNT_LAST      = 6'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL      = 6'(FRAME_BITS);

    logic sck_level, sck_rise, sck_fall;
    logic nscs_level, nscs_rise, nscs_fall;
    logic mosi_meta_q, mosi_sync_q;

    tcm4671_sync #(.RESET_VAL(1'b1)) u_sync_sck (
        .clk(clk), .reset(reset), .d_i(SCK),
        .level_o(sck_level), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    tcm4671_sync #(.RESET_VAL(1'b1)) u_sync_nscs (
        .clk(clk), .reset(reset), .d_i(nSCS),
        .level_o(nscs_level), .rise_o(nscs_rise), .fall_o(nscs_fall)
    );

    // MOSI shares the SCK latency so it is aligned with the detected edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            mosi_meta_q <= MOSI;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    logic [DATA_W-1:0]     regs_q [NUM_REGS];
    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [FRAME_BITS-1:0] shift_in_q;
    logic [DATA_W-1:0]     shift_out_q;
    logic                  miso_q, over_q, armed_q;
    logic [1:0]            settle_q;
    logic                  wr_strobe_q, rd_strobe_q, frame_error_q;
    logic [ADDR_W-1:0]     wr_addr_q, rd_addr_q;
    logic [DATA_W-1:0]     wr_data_q;

    // Address being completed on the 8th rising edge and its register value.
    logic [ADDR_W-1:0] frame_addr;
    logic [DATA_W-1:0] frame_rdata;
    assign frame_addr  = {shift_in_q[5:0], mosi_sync_q};
    assign frame_rdata = ({1'b0, frame_addr} < NUM_REGS_L) ? regs_q[frame_addr[IDX_W-1:0]] : '0;
    assign host_data   = ({1'b0, host_addr} < NUM_REGS_L) ? regs_q[host_addr[IDX_W-1:0]] : '0;

    // Register file: each word is written from the committed-write strobe.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            // Per-word storage, cleared on reset.
            always_ff @(posedge clk) begin
                if (reset) begin
                    regs_q[gi] <= '0;
                end else if (wr_strobe_q && (wr_addr_q == ADDR_W'(gi))) begin
                    regs_q[gi] <= wr_data_q;
                end
            end
        end
    endgenerate

    // Frame FSM: shifting, register fetch, commit/abort and output pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            shift_in_q    <= '0;
            shift_out_q   <= '0;
            miso_q        <= 1'b0;
            over_q        <= 1'b0;
            armed_q       <= 1'b0;
            settle_q      <= 2'b00;
            wr_strobe_q   <= 1'b0;
            rd_strobe_q   <= 1'b0;
            frame_error_q <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            rd_addr_q     <= '0;
        end else begin
            wr_strobe_q   <= 1'b0;
            rd_strobe_q   <= 1'b0;
            frame_error_q <= 1'b0;
            // Synchronizer outputs are stale for two cycles after reset; a
            // frame may only start once an idle bus has really been seen.
            settle_q <= {settle_q[0], 1'b1};
            if (settle_q[1] && nscs_level && sck_level) begin
                armed_q <= 1'b1;
            end

            if (nscs_rise) begin
                if (state_q != IDLE) begin
                    if ((cnt_q == CNT_FULL) && !over_q) begin
                        if (shift_in_q[FRAME_BITS-1]) begin
                            wr_strobe_q <= 1'b1;
                            wr_addr_q   <= shift_in_q[FRAME_BITS-2:DATA_W];
                            wr_data_q   <= shift_in_q[DATA_W-1:0];
                        end
                    end else begin
                        frame_error_q <= 1'b1;
                    end
                end
                state_q <= IDLE;
                cnt_q   <= '0;
                over_q  <= 1'b0;
                miso_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (nscs_fall && armed_q) begin
                            state_q    <= ADDR;
                            cnt_q      <= '0;
                            shift_in_q <= '0;
                            over_q     <= 1'b0;
                            miso_q     <= 1'b0;
                        end
                    end
                    ADDR: begin
                        if (sck_rise && !nscs_level) begin
                            shift_in_q <= {shift_in_q[FRAME_BITS-2:0], mosi_sync_q};
                            cnt_q      <= cnt_q + 6'd1;
                            if (cnt_q == CNT_ADDR_LAST) begin
                                state_q     <= DATA;
                                shift_out_q <= frame_rdata;
                                if (!shift_in_q[6]) begin
                                    rd_strobe_q <= 1'b1;
                                    rd_addr_q   <= frame_addr;
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (!nscs_level) begin
                            if (sck_rise) begin
                                shift_in_q <= {shift_in_q[FRAME_BITS-2:0], mosi_sync_q};
                                cnt_q      <= cnt_q + 6'd1;
                                if (cnt_q == CNT_LAST) begin
                                    state_q <= WAIT_CS;
                                end
                            end else if (sck_fall) begin
                                miso_q      <= shift_out_q[DATA_W-1];
                                shift_out_q <= {shift_out_q[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                    WAIT_CS: begin
                        // Extra clocks are not shifted but spoil the frame.
                        if (sck_rise && !nscs_level) begin
                            over_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign MISO        = miso_q;
    assign MISO_oe     = ~nscs_level;
    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign rd_strobe   = rd_strobe_q;
    assign rd_addr     = rd_addr_q;
    assign frame_error = frame_error_q;

endmodule

// File: doc/tcm4671_spi_target.md
TCM4671_SPI_TARGET -- requirements
Module: tcm4671_spi_target

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of implemented 32-bit registers (addresses 0..NUM_REGS-1, NUM_REGS <= 128).
REQ-002 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port SCK  input  1  SPI clock from the master, asynchronous to clk, idle high.
REQ-005 SHALL have port nSCS  input  1  chip select, active low, asynchronous.
REQ-006 SHALL have port MOSI  input  1  master-to-target serial data.
REQ-007 SHALL have port MISO  output  1  target-to-master serial data.
REQ-008 SHALL have port MISO_oe  output  1  high while the target drives MISO.
REQ-009 SHALL have ports wr_strobe / wr_addr / wr_data  output  1/7/32  one-cycle pulse with address and data of each committed write frame.
REQ-010 SHALL have ports rd_strobe / rd_addr  output  1/7  one-cycle pulse when a read frame's address is captured.
REQ-011 SHALL have port frame_error  output  1  one-cycle pulse on each malformed frame.
REQ-012 SHALL have ports host_addr / host_data  input 7 / output 32  combinational fabric-side read of the register file, 0 when out of range.

Function
REQ-013 SHALL double-flop SCK, nSCS and MOSI into clk, then detect edges; edge-to-action latency is 3 clk cycles max; SCK half-period SHALL be >= 3 clk cycles.
REQ-014 SHALL use frame format MSB first, 40 bits: bit39 writeNOTread, bits38:32 address, bits31:0 data.
REQ-015 SHALL sample MOSI on each detected SCK rising edge while nSCS low, and SHALL update MISO on each detected SCK falling edge.
REQ-016 SHALL implement FSM states IDLE, ADDR, DATA, WAIT_CS: IDLE->ADDR on nSCS fall; ADDR->DATA after 8th rising edge; DATA->WAIT_CS after 40th rising edge; any state->IDLE on nSCS rise.
REQ-017 SHALL, at the 8th rising edge, load a 32-bit shift register with reg[address] (0 if out of range), and for reads pulse rd_strobe with rd_addr.
REQ-018 SHALL present shift-register bit31 on MISO at the falling edge following the 8th rising edge, then shift one bit per falling edge; MISO SHALL be 0 in IDLE and ADDR.
REQ-019 SHALL, on nSCS rise after exactly 40 rising edges with bit39=1, pulse wr_strobe one cycle with wr_addr/wr_data and write reg[address] if address < NUM_REGS.
REQ-020 SHALL leave registers unchanged for writes with address >= NUM_REGS, while still pulsing wr_strobe.
REQ-021 SHALL treat nSCS rise with fewer than 40 rising edges as an aborted frame: no write, no wr_strobe, frame_error pulse.
REQ-022 SHALL ignore rising edges beyond 40; nSCS rise then pulses frame_error, no write.
REQ-023 SHALL hold MISO_oe high exactly while synchronized nSCS is low.
REQ-024 SHALL ignore SCK edges while nSCS is high.
REQ-025 SHALL make a read frame always return the register value as of its 8th rising edge, including immediately after a preceding write to the same address.

Reset
REQ-026 SHALL, on reset, clear all registers, shift registers and bit counter to 0, force FSM to IDLE, drive MISO=0, MISO_oe=0, wr_strobe=0, rd_strobe=0, frame_error=0, wr_addr=0, wr_data=0, rd_addr=0.
REQ-027 SHALL, when reset is asserted mid-frame, discard the frame; after reset release with nSCS still low, the target SHALL remain in IDLE until the next nSCS fall.

Structure
REQ-028 SHALL take FRAME_BITS=40, ADDR_W=7, DATA_W=32 and the FSM state enum from the shared package tcm4671_pkg.
REQ-029 SHALL instantiate the sub-module tcm4671_sync (two-flop synchronizer with rise/fall detect), once each for SCK and nSCS, and plain two-flop synchronization for MOSI.

Verification
REQ-030 SHALL verify: write frame 1/0x05/0xDEADBEEF at SCK = clk/8 -> one wr_strobe, wr_addr=0x05, wr_data=0xDEADBEEF, host_addr=5 reads 0xDEADBEEF.
REQ-031 SHALL verify: after REQ-030, read frame 0/0x05 with a 500 ns gap after the address byte -> rd_strobe with rd_addr=0x05, master captures 0xDEADBEEF.
REQ-032 SHALL verify: nSCS rises after 20 bits of a write to 0x03 -> frame_error pulse, no wr_strobe, reg[3] stays 0.
REQ-033 SHALL verify: write 0x12345678 to address 0x40 -> wr_strobe, wr_addr=0x40, host_addr=0x40 reads 0, subsequent read of 0x40 returns 0.
REQ-034 SHALL verify: 41 SCK cycles on a write to 0x02 -> frame_error pulse, reg[2] unchanged.
REQ-035 SHALL verify: reset asserted at bit 30 of a write to 0x01 -> no wr_strobe, all outputs at reset values; the next full frame completes normally.
